alu_rs_scheduler: RTL and testbench

Reservation station and issue scheduler for the single shared ALU. It accepts decoded ALU-class instructions from dispatch and holds them in ENTRIES slots. It snoops two result broadcast buses to resolve operand tags, and issues one operand-complete instruction per cycle into the ALU's combinational input. A ROB flush discards all held and in-flight work.

---
 rtl/alu_rs_scheduler_if.sv | 48 ++++
 rtl/alu_rs_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_scheduler_if.sv
// Dispatch, result-broadcast and ALU-issue signals of the ALU reservation station.
interface alu_rs_scheduler_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned OP_W   = 6
);
    logic              dec_rs_valid_in;
    logic [OP_W-1:0]   dec_rs_opcode_in;
    logic [TAG_W-1:0]  dec_rs_qj_in;
    logic [TAG_W-1:0]  dec_rs_qk_in;
    logic [DATA_W-1:0] dec_rs_vj_in;
    logic [DATA_W-1:0] dec_rs_vk_in;
    logic [DATA_W-1:0] dec_rs_a_in;
    logic [ADDR_W-1:0] dec_rs_pc_in;
    logic [TAG_W-1:0]  dec_rs_dest_in;
    logic              rs_dec_full_out;

    logic [TAG_W-1:0]  cdb0_h_in;
    logic [DATA_W-1:0] cdb0_result_in;
    logic [TAG_W-1:0]  cdb1_h_in;
    logic [DATA_W-1:0] cdb1_result_in;

    logic [OP_W-1:0]   rs_alu_opcode_out;
    logic [DATA_W-1:0] rs_alu_vj_out;
    logic [DATA_W-1:0] rs_alu_vk_out;
    logic [DATA_W-1:0] rs_alu_a_out;
    logic [ADDR_W-1:0] rs_alu_pc_out;
    logic [TAG_W-1:0]  rs_alu_dest_out;

    // Dispatch/ROB/ALU side: drives requests and broadcasts, observes issue.
    modport master (
        output dec_rs_valid_in, dec_rs_opcode_in, dec_rs_qj_in, dec_rs_qk_in,
               dec_rs_vj_in, dec_rs_vk_in, dec_rs_a_in, dec_rs_pc_in, dec_rs_dest_in,
               cdb0_h_in, cdb0_result_in, cdb1_h_in, cdb1_result_in,
        input  rs_dec_full_out, rs_alu_opcode_out, rs_alu_vj_out, rs_alu_vk_out,
               rs_alu_a_out, rs_alu_pc_out, rs_alu_dest_out
    );

    // Reservation station side.
    modport slave (
        input  dec_rs_valid_in, dec_rs_opcode_in, dec_rs_qj_in, dec_rs_qk_in,
               dec_rs_vj_in, dec_rs_vk_in, dec_rs_a_in, dec_rs_pc_in, dec_rs_dest_in,
               cdb0_h_in, cdb0_result_in, cdb1_h_in, cdb1_result_in,
        output rs_dec_full_out, rs_alu_opcode_out, rs_alu_vj_out, rs_alu_vk_out,
               rs_alu_a_out, rs_alu_pc_out, rs_alu_dest_out
    );
endinterface

// File: rtl/alu_rs_scheduler.sv
// Reservation station for the shared ALU: holds dispatched ops, snoops two
// result buses for operand tags, and issues the lowest-index ready slot per cycle.
module alu_rs_scheduler #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ENTRIES = 8
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic rob_rs_rst_in,
    alu_rs_scheduler_if.slave bus
);
    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   opcode;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qk;
        logic [DATA_W-1:0] vk;
        logic [DATA_W-1:0] a;
        logic [ADDR_W-1:0] pc;
        logic [TAG_W-1:0]  dest;
    } slot_t;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [DATA_W-1:0] a;
        logic [ADDR_W-1:0] pc;
        logic [TAG_W-1:0]  dest;
    } issue_t;

    typedef struct packed {
        logic [TAG_W-1:0]  q;
        logic [DATA_W-1:0] v;
    } operand_t;

    slot_t              slots     [ENTRIES];
    slot_t              slots_nxt [ENTRIES];
    issue_t             iss;
    issue_t             iss_nxt;
    logic [ENTRIES-1:0] busy_vec;
    logic [ENTRIES-1:0] ready_vec;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               issue_hit;
    logic               free_hit;

    // Resolve one operand against both broadcast buses; cdb0 takes precedence.
    function automatic operand_t snoop(
        input logic [TAG_W-1:0]  q,
        input logic [DATA_W-1:0] v,
        input logic [TAG_W-1:0]  h0,
        input logic [DATA_W-1:0] d0,
        input logic [TAG_W-1:0]  h1,
        input logic [DATA_W-1:0] d1
    );
        operand_t r;
        r.q = q;
        r.v = v;
        if (q != '0) begin
            if (q == h0) begin
                r.q = '0;
                r.v = d0;
            end else if (q == h1) begin
                r.q = '0;
                r.v = d1;
            end
        end
        return r;
    endfunction

    // Per-slot busy and operand-complete flags from registered state.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            busy_vec[i]  = slots[i].busy;
            ready_vec[i] = slots[i].busy && (slots[i].qj == '0) && (slots[i].qk == '0);
        end
    end

    // Lowest-index ready slot for issue and lowest-index free slot for dispatch.
    always_comb begin
        issue_hit = 1'b0;
        issue_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                issue_hit = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!busy_vec[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign bus.rs_dec_full_out = &busy_vec;

    // Next station/issue state: flush overrides; otherwise issue, wakeup and dispatch together.
    always_comb begin
        operand_t opj;
        operand_t opk;
        slots_nxt = slots;
        iss_nxt   = iss;
        opj       = '0;
        opk       = '0;
        if (rdy_in) begin
            if (rob_rs_rst_in) begin
                for (int i = 0; i < int'(ENTRIES); i++) begin
                    slots_nxt[i].busy = 1'b0;
                end
                iss_nxt = '0;
            end else begin
                iss_nxt = '0;
                if (issue_hit) begin
                    iss_nxt.opcode = slots[issue_idx].opcode;
                    iss_nxt.vj     = slots[issue_idx].vj;
                    iss_nxt.vk     = slots[issue_idx].vk;
                    iss_nxt.a      = slots[issue_idx].a;
                    iss_nxt.pc     = slots[issue_idx].pc;
                    iss_nxt.dest   = slots[issue_idx].dest;
                end

                for (int i = 0; i < int'(ENTRIES); i++) begin
                    if (slots[i].busy) begin
                        opj = snoop(slots[i].qj, slots[i].vj, bus.cdb0_h_in, bus.cdb0_result_in,
                                    bus.cdb1_h_in, bus.cdb1_result_in);
                        opk = snoop(slots[i].qk, slots[i].vk, bus.cdb0_h_in, bus.cdb0_result_in,
                                    bus.cdb1_h_in, bus.cdb1_result_in);
                        slots_nxt[i].qj = opj.q;
                        slots_nxt[i].vj = opj.v;
                        slots_nxt[i].qk = opk.q;
                        slots_nxt[i].vk = opk.v;
                    end
                end

                if (issue_hit) begin
                    slots_nxt[issue_idx].busy = 1'b0;
                end

                // Free slot is chosen from registered state, so it never aliases the issuing slot.
                if (bus.dec_rs_valid_in && free_hit) begin
                    opj = snoop(bus.dec_rs_qj_in, bus.dec_rs_vj_in, bus.cdb0_h_in, bus.cdb0_result_in,
                                bus.cdb1_h_in, bus.cdb1_result_in);
                    opk = snoop(bus.dec_rs_qk_in, bus.dec_rs_vk_in, bus.cdb0_h_in, bus.cdb0_result_in,
                                bus.cdb1_h_in, bus.cdb1_result_in);
                    slots_nxt[free_idx].busy   = 1'b1;
                    slots_nxt[free_idx].opcode = bus.dec_rs_opcode_in;
                    slots_nxt[free_idx].qj     = opj.q;
                    slots_nxt[free_idx].vj     = opj.v;
                    slots_nxt[free_idx].qk     = opk.q;
                    slots_nxt[free_idx].vk     = opk.v;
                    slots_nxt[free_idx].a      = bus.dec_rs_a_in;
                    slots_nxt[free_idx].pc     = bus.dec_rs_pc_in;
                    slots_nxt[free_idx].dest   = bus.dec_rs_dest_in;
                end
            end
        end
    end

    // State registers for station slots and issue outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                slots[i] <= '0;
            end
            iss <= '0;
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                slots[i] <= slots_nxt[i];
            end
            iss <= iss_nxt;
        end
    end

    assign bus.rs_alu_opcode_out = iss.opcode;
    assign bus.rs_alu_vj_out     = iss.vj;
    assign bus.rs_alu_vk_out     = iss.vk;
    assign bus.rs_alu_a_out      = iss.a;
    assign bus.rs_alu_pc_out     = iss.pc;
    assign bus.rs_alu_dest_out   = iss.dest;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed scenarios plus randomized traffic against a slot-list model.
module tb_alu_rs_scheduler;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ENTRIES = 8;

    logic clk = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic rob_rs_rst_in;

    always #5 clk = ~clk;

    alu_rs_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

    alu_rs_scheduler #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .OP_W(OP_W), .ENTRIES(ENTRIES)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rob_rs_rst_in(rob_rs_rst_in),
        .bus          (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [3:0]  dest;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
        logic [31:0] pc;
    } mslot_t;

    mslot_t      m [ENTRIES];
    logic [5:0]  e_op;
    logic [31:0] e_vj, e_vk, e_a, e_pc;
    logic [3:0]  e_dest;

    // Reference model ---------------------------------------------------------
    function automatic bit model_full();
        for (int i = 0; i < int'(ENTRIES); i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void resolve(inout logic [3:0] q, inout logic [31:0] v);
        if (q == 4'd0) return;
        if (q == bus.cdb0_h_in) begin
            q = 4'd0; v = bus.cdb0_result_in;
        end else if (q == bus.cdb1_h_in) begin
            q = 4'd0; v = bus.cdb1_result_in;
        end
    endfunction

    task automatic clear_issue();
        e_op = '0; e_vj = '0; e_vk = '0; e_a = '0; e_pc = '0; e_dest = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) m[i].busy = 1'b0;
        clear_issue();
    endtask

    task automatic model_step();
        int sel = -1;
        int fr  = -1;
        if (!rdy_in) return;
        if (rob_rs_rst_in) begin
            model_reset();
            return;
        end
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (sel < 0 && m[i].busy && m[i].qj == 4'd0 && m[i].qk == 4'd0) sel = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        clear_issue();
        if (sel >= 0) begin
            e_op = m[sel].op; e_vj = m[sel].vj; e_vk = m[sel].vk;
            e_a = m[sel].a; e_pc = m[sel].pc; e_dest = m[sel].dest;
        end
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (m[i].busy) begin
                resolve(m[i].qj, m[i].vj);
                resolve(m[i].qk, m[i].vk);
            end
        end
        if (sel >= 0) m[sel].busy = 1'b0;
        if (bus.dec_rs_valid_in && fr >= 0) begin
            m[fr].busy = 1'b1;
            m[fr].op = bus.dec_rs_opcode_in;
            m[fr].qj = bus.dec_rs_qj_in; m[fr].vj = bus.dec_rs_vj_in;
            m[fr].qk = bus.dec_rs_qk_in; m[fr].vk = bus.dec_rs_vk_in;
            m[fr].a = bus.dec_rs_a_in; m[fr].pc = bus.dec_rs_pc_in;
            m[fr].dest = bus.dec_rs_dest_in;
            resolve(m[fr].qj, m[fr].vj);
            resolve(m[fr].qk, m[fr].vk);
        end
    endtask

    // Stimulus helpers ----------------------------------------------------------
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [3:0] qj, input logic [31:0] vj,
                            input logic [3:0] qk, input logic [31:0] vk, input logic [31:0] a,
                            input logic [31:0] pc, input logic [3:0] dest);
        bus.dec_rs_valid_in = 1'b1;
        bus.dec_rs_opcode_in = op;
        bus.dec_rs_qj_in = qj; bus.dec_rs_vj_in = vj;
        bus.dec_rs_qk_in = qk; bus.dec_rs_vk_in = vk;
        bus.dec_rs_a_in = a; bus.dec_rs_pc_in = pc; bus.dec_rs_dest_in = dest;
    endtask

    task automatic idle();
        bus.dec_rs_valid_in = 1'b0;
        bus.cdb0_h_in = '0; bus.cdb0_result_in = '0;
        bus.cdb1_h_in = '0; bus.cdb1_result_in = '0;
    endtask

    // Scenarios ---------------------------------------------------------------
    task automatic test_reset();
        rdy_in = 1'b1; rob_rs_rst_in = 1'b0; rst_in = 1'b0;
        idle();
        dispatch('0, '0, '0, '0, '0, '0, '0, '0);
        bus.dec_rs_valid_in = 1'b0;
        model_reset();
        #12;
        vectors++;
        if ({bus.rs_alu_opcode_out, bus.rs_alu_vj_out, bus.rs_alu_vk_out, bus.rs_alu_a_out,
             bus.rs_alu_pc_out, bus.rs_alu_dest_out, bus.rs_dec_full_out} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got op=%h dest=%h full=%b, expected all zero",
                     bus.rs_alu_opcode_out, bus.rs_alu_dest_out, bus.rs_dec_full_out);
        end
        @(negedge clk);
        rst_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_simple_issue();
        dispatch(6'h13, 4'd0, 32'd5, 4'd0, 32'd0, 32'd3, 32'h100, 4'd2);
        cycle();
        idle();
        vectors++;
        if (bus.rs_alu_opcode_out !== 6'h00) begin
            miscompares++;
            $display("FAIL simple_not_early: got op=%h expected 00", bus.rs_alu_opcode_out);
        end
        cycle();
        vectors++;
        if ({bus.rs_alu_opcode_out, bus.rs_alu_vj_out, bus.rs_alu_a_out, bus.rs_alu_pc_out, bus.rs_alu_dest_out}
            !== {6'h13, 32'd5, 32'd3, 32'h100, 4'd2}) begin
            miscompares++;
            $display("FAIL simple_issue: got op=%h vj=%h a=%h dest=%h expected 13/5/3/2",
                     bus.rs_alu_opcode_out, bus.rs_alu_vj_out, bus.rs_alu_a_out, bus.rs_alu_dest_out);
        end
        cycle();
        vectors++;
        if ({bus.rs_alu_opcode_out, bus.rs_alu_dest_out} !== 10'd0) begin
            miscompares++;
            $display("FAIL simple_idle: got op=%h dest=%h expected 00/0", bus.rs_alu_opcode_out, bus.rs_alu_dest_out);
        end
    endtask

    task automatic test_wakeup();
        dispatch(6'h33, 4'd3, 32'd0, 4'd0, 32'd7, 32'd0, 32'h200, 4'd4);
        cycle();
        idle();
        cycle();
        vectors++;
        if (bus.rs_alu_dest_out !== 4'd0) begin
            miscompares++;
            $display("FAIL wakeup_waiting: got dest=%h expected 0", bus.rs_alu_dest_out);
        end
        bus.cdb1_h_in = 4'd3; bus.cdb1_result_in = 32'd10;
        cycle();
        idle();
        vectors++;
        if (bus.rs_alu_dest_out !== 4'd0) begin
            miscompares++;
            $display("FAIL wakeup_not_early: got dest=%h expected 0", bus.rs_alu_dest_out);
        end
        cycle();
        vectors++;
        if ({bus.rs_alu_opcode_out, bus.rs_alu_vj_out, bus.rs_alu_vk_out, bus.rs_alu_dest_out}
            !== {6'h33, 32'd10, 32'd7, 4'd4}) begin
            miscompares++;
            $display("FAIL wakeup_issue: got op=%h vj=%h vk=%h dest=%h expected 33/a/7/4",
                     bus.rs_alu_opcode_out, bus.rs_alu_vj_out, bus.rs_alu_vk_out, bus.rs_alu_dest_out);
        end
        cycle();
    endtask

    task automatic test_dispatch_bypass();
        dispatch(6'h33, 4'd5, 32'd0, 4'd0, 32'd1, 32'd0, 32'h300, 4'd6);
        bus.cdb0_h_in = 4'd5; bus.cdb0_result_in = 32'h1234;
        cycle();
        idle();
        cycle();
        vectors++;
        if ({bus.rs_alu_vj_out, bus.rs_alu_dest_out} !== {32'h1234, 4'd6}) begin
            miscompares++;
            $display("FAIL bypass_issue: got vj=%h dest=%h expected 1234/6", bus.rs_alu_vj_out, bus.rs_alu_dest_out);
        end
        cycle();
    endtask

    task automatic test_fill_and_drain();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            dispatch(6'h33, 4'd6, 32'd0, 4'd0, 32'(i), 32'd0, 32'(i * 4), 4'(i + 1));
            cycle();
        end
        vectors++;
        if (bus.rs_dec_full_out !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_full: got %b expected 1", bus.rs_dec_full_out);
        end
        dispatch(6'h3f, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd15);
        cycle();
        idle();
        bus.cdb0_h_in = 4'd6; bus.cdb0_result_in = 32'hAB;
        cycle();
        idle();
        vectors++;
        if ({bus.rs_dec_full_out, bus.rs_alu_dest_out} !== {1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL fill_hold: got full=%b dest=%h expected 1/0", bus.rs_dec_full_out, bus.rs_alu_dest_out);
        end
        for (int i = 0; i < int'(ENTRIES); i++) begin
            cycle();
            vectors++;
            if ({bus.rs_alu_dest_out, bus.rs_alu_vj_out, bus.rs_alu_vk_out, bus.rs_dec_full_out}
                !== {4'(i + 1), 32'hAB, 32'(i), 1'b0}) begin
                miscompares++;
                $display("FAIL drain_order[%0d]: got dest=%h vj=%h vk=%h full=%b expected %h/ab/%h/0",
                         i, bus.rs_alu_dest_out, bus.rs_alu_vj_out, bus.rs_alu_vk_out,
                         bus.rs_dec_full_out, i + 1, i);
            end
        end
        cycle();
        vectors++;
        if (bus.rs_alu_dest_out !== 4'd0) begin
            miscompares++;
            $display("FAIL drain_dropped: got dest=%h expected 0", bus.rs_alu_dest_out);
        end
    endtask

    task automatic test_flush();
        dispatch(6'h33, 4'd9, 32'd0, 4'd0, 32'd0, 32'd0, 32'h400, 4'd1);
        cycle();
        dispatch(6'h33, 4'd9, 32'd0, 4'd0, 32'd0, 32'd0, 32'h404, 4'd2);
        cycle();
        dispatch(6'h13, 4'd0, 32'd1, 4'd0, 32'd0, 32'd0, 32'h408, 4'd3);
        cycle();
        dispatch(6'h13, 4'd0, 32'd2, 4'd0, 32'd0, 32'd0, 32'h40c, 4'd5);
        rob_rs_rst_in = 1'b1;
        cycle();
        rob_rs_rst_in = 1'b0;
        idle();
        vectors++;
        if ({bus.rs_alu_opcode_out, bus.rs_alu_dest_out, bus.rs_dec_full_out} !== 11'd0) begin
            miscompares++;
            $display("FAIL flush_clear: got op=%h dest=%h full=%b expected 0/0/0",
                     bus.rs_alu_opcode_out, bus.rs_alu_dest_out, bus.rs_dec_full_out);
        end
        bus.cdb0_h_in = 4'd9; bus.cdb0_result_in = 32'h55;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (bus.rs_alu_dest_out !== 4'd0) begin
                miscompares++;
                $display("FAIL flush_no_issue[%0d]: got dest=%h expected 0", i, bus.rs_alu_dest_out);
            end
        end
    endtask

    task automatic test_freeze_and_async_reset();
        dispatch(6'h13, 4'd0, 32'h11, 4'd0, 32'd0, 32'd0, 32'h500, 4'd1);
        cycle();
        dispatch(6'h14, 4'd0, 32'h22, 4'd0, 32'd0, 32'd0, 32'h504, 4'd2);
        cycle();
        rdy_in = 1'b0;
        dispatch(6'h15, 4'd0, 32'h33, 4'd0, 32'd0, 32'd0, 32'h508, 4'd3);
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if ({bus.rs_alu_opcode_out, bus.rs_alu_vj_out, bus.rs_alu_dest_out} !== {6'h13, 32'h11, 4'd1}) begin
                miscompares++;
                $display("FAIL freeze_hold[%0d]: got op=%h vj=%h dest=%h expected 13/11/1",
                         i, bus.rs_alu_opcode_out, bus.rs_alu_vj_out, bus.rs_alu_dest_out);
            end
        end
        rdy_in = 1'b1;
        idle();
        cycle();
        vectors++;
        if ({bus.rs_alu_opcode_out, bus.rs_alu_dest_out} !== {6'h14, 4'd2}) begin
            miscompares++;
            $display("FAIL freeze_resume: got op=%h dest=%h expected 14/2", bus.rs_alu_opcode_out, bus.rs_alu_dest_out);
        end
        cycle();
        vectors++;
        if (bus.rs_alu_dest_out !== 4'd0) begin
            miscompares++;
            $display("FAIL freeze_dropped: got dest=%h expected 0", bus.rs_alu_dest_out);
        end
        dispatch(6'h16, 4'd0, 32'h44, 4'd0, 32'd0, 32'd0, 32'h50c, 4'd4);
        cycle();
        dispatch(6'h16, 4'd7, 32'h0, 4'd0, 32'd0, 32'd0, 32'h510, 4'd5);
        cycle();
        idle();
        vectors++;
        if (bus.rs_alu_dest_out !== 4'd4) begin
            miscompares++;
            $display("FAIL pre_reset_issue: got dest=%h expected 4", bus.rs_alu_dest_out);
        end
        rst_in = 1'b0;
        #2;
        model_reset();
        vectors++;
        if ({bus.rs_alu_opcode_out, bus.rs_alu_vj_out, bus.rs_alu_pc_out, bus.rs_alu_dest_out,
             bus.rs_dec_full_out} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got op=%h dest=%h expected 0/0", bus.rs_alu_opcode_out, bus.rs_alu_dest_out);
        end
        rst_in = 1'b1;
        bus.cdb0_h_in = 4'd7; bus.cdb0_result_in = 32'h66;
        cycle();
        idle();
        cycle();
        vectors++;
        if (bus.rs_alu_dest_out !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_cleared_slot: got dest=%h expected 0", bus.rs_alu_dest_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rdy_in = ($urandom_range(7) != 0);
            rob_rs_rst_in = ($urandom_range(31) == 0);
            bus.dec_rs_valid_in = ($urandom_range(9) < 6);
            bus.dec_rs_opcode_in = 6'($urandom_range(63, 1));
            bus.dec_rs_qj_in = $urandom_range(1) ? 4'd0 : 4'($urandom_range(3, 1));
            bus.dec_rs_qk_in = $urandom_range(1) ? 4'd0 : 4'($urandom_range(3, 1));
            bus.dec_rs_vj_in = $urandom; bus.dec_rs_vk_in = $urandom;
            bus.dec_rs_a_in = $urandom; bus.dec_rs_pc_in = $urandom;
            bus.dec_rs_dest_in = 4'($urandom_range(15, 1));
            bus.cdb0_h_in = rdy_in ? 4'($urandom_range(3)) : 4'd0;
            bus.cdb1_h_in = rdy_in ? 4'($urandom_range(3)) : 4'd0;
            bus.cdb0_result_in = $urandom; bus.cdb1_result_in = $urandom;
            cycle();
            vectors++;
            if ({bus.rs_alu_opcode_out, bus.rs_alu_vj_out, bus.rs_alu_vk_out, bus.rs_alu_a_out,
                 bus.rs_alu_pc_out, bus.rs_alu_dest_out, bus.rs_dec_full_out}
                !== {e_op, e_vj, e_vk, e_a, e_pc, e_dest, model_full()}) begin
                miscompares++;
                $display("FAIL random[%0d]: got op=%h vj=%h vk=%h dest=%h full=%b expected op=%h vj=%h vk=%h dest=%h full=%b",
                         n, bus.rs_alu_opcode_out, bus.rs_alu_vj_out, bus.rs_alu_vk_out,
                         bus.rs_alu_dest_out, bus.rs_dec_full_out, e_op, e_vj, e_vk, e_dest, model_full());
            end
        end
        rdy_in = 1'b1;
        rob_rs_rst_in = 1'b0;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_simple_issue();
        test_wakeup();
        test_dispatch_bypass();
        test_fill_and_drain();
        test_flush();
        test_freeze_and_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
